// File: rtl/ebr_burst_reader_if.sv
// Bus bundle for ebr_burst_reader: burst command, EBR read port and output stream.
// Latency: none, wires only.
// Backpressure: stream side is DVALID/DREADY; command side has none (START is ignored while BUSY).
//
// Ports: START/BASE_AD/LEN command and BUSY/DONE status; AD/CE/OCE/WE/DI to the EBR port;
// DOUT/DVALID/DREADY/DLAST output stream. master = the reader, slave = its environment.
interface ebr_burst_reader_if #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 10
);
  // command / status
  logic                  START;
  logic [ADDR_WIDTH-1:0] BASE_AD;
  logic [ADDR_WIDTH:0]   LEN;
  logic                  BUSY;
  logic                  DONE;
  // EBR port
  logic [ADDR_WIDTH-1:0] AD;
  logic                  CE;
  logic                  OCE;
  logic                  WE;
  logic [DATA_WIDTH-1:0] DI;
  // output stream
  logic [DATA_WIDTH-1:0] DOUT;
  logic                  DVALID;
  logic                  DREADY;
  logic                  DLAST;

  modport master (
    input  START, BASE_AD, LEN, DI, DREADY,
    output BUSY, DONE, AD, CE, OCE, WE, DOUT, DVALID, DLAST
  );

  modport slave (
    output START, BASE_AD, LEN, DI, DREADY,
    input  BUSY, DONE, AD, CE, OCE, WE, DOUT, DVALID, DLAST
  );
endinterface

// File: rtl/ebr_burst_reader.sv
// Sequential read-burst master for a single-port EBR, streaming words out with a last marker.
// Latency: first CE one cycle after START; first DVALID READ_LAT+1 cycles after that CE.
// Backpressure: DREADY stalls the FIFO; issue is gated by a credit check so no read is lost.
//
// Ports: CLK/RST (synchronous, active-high) plus one ebr_burst_reader_if.master bundle.
// The small FIFO below is a generic helper used only by the reader.

// Generic synchronous FIFO: head is shown combinationally, one push and one pop per cycle.
// Latency: a word pushed at an edge is visible on rd_dat the following cycle.
// Backpressure: none on the write side; the writer must never push into a full FIFO.
module ebr_brd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_vld = (count_q != '0);
  assign rd_dat = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign pop    = rd_vld && rd_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_vld) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({wr_vld, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared too so the stream outputs read as zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module ebr_burst_reader #(
  parameter int    DATA_WIDTH = 9,
  parameter int    ADDR_WIDTH = 10,
  parameter string REGMODE    = "NOREG",
  parameter int    FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  ebr_burst_reader_if.master bus
);
  // FIFO_DEPTH must be at least READ_LAT+2 to sustain one word per cycle.
  localparam int READ_LAT = (REGMODE == "OUTREG") ? 2 : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W    = CNT_W + 1;
  localparam int LEN_W    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] dat;
  } word_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [READ_LAT-1:0]   vld_sr_q, vld_sr_d;
  logic [READ_LAT-1:0]   last_sr_q, last_sr_d;
  logic                  done_q, done_d;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_vld;
  word_t                 fifo_head;
  word_t                 fifo_in;
  logic                  push;
  logic [SUM_W-1:0]      inflight;
  logic                  credit_ok;
  logic                  issue;
  logic                  start_go;
  logic                  start_zero;
  logic                  last_pop;
  logic                  drain_exit;

  assign start_go   = (state_q == S_IDLE) && bus.START && (bus.LEN != '0);
  assign start_zero = (state_q == S_IDLE) && bus.START && (bus.LEN == '0);

  // Reads still travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + SUM_W'(vld_sr_q[i]);
    end
  end

  // Every issued read already owns a FIFO slot. A pop in this cycle is not credited
  // back until the next cycle, which keeps the check purely registered.
  assign credit_ok = (SUM_W'(fifo_count) + inflight) < SUM_W'(FIFO_DEPTH);
  assign issue     = (state_q == S_ISSUE) && credit_ok;

  // The oldest pipeline bit lines up with DI carrying that read's data.
  assign push    = vld_sr_q[READ_LAT-1];
  assign fifo_in = {last_sr_q[READ_LAT-1], bus.DI};

  assign last_pop   = fifo_vld && bus.DREADY && fifo_head.last;
  assign drain_exit = (state_q == S_DRAIN) && last_pop && (inflight == '0);

  ebr_brd_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .wr_vld (push),
    .wr_dat (fifo_in),
    .rd_vld (fifo_vld),
    .rd_rdy (bus.DREADY),
    .rd_dat (fifo_head),
    .count  (fifo_count)
  );

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_d = S_ISSUE;
      S_ISSUE: if (issue && (rem_q == LEN_W'(1))) state_d = S_DRAIN;
      S_DRAIN: if (drain_exit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.BUSY   = (state_q != S_IDLE);
    bus.DONE   = done_q;
    bus.CE     = issue;
    bus.AD     = addr_q;
    bus.OCE    = 1'b1;
    bus.WE     = 1'b0;
    bus.DOUT   = fifo_head.dat;
    bus.DLAST  = fifo_head.last;
    bus.DVALID = fifo_vld;
  end

  // Address/remaining counters and the in-flight pipeline.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (start_go) begin
      addr_d = bus.BASE_AD;
      rem_d  = bus.LEN;
    end else if (issue) begin
      addr_d = addr_q + ADDR_WIDTH'(1);  // wraps naturally at 2^ADDR_WIDTH
      rem_d  = rem_q - LEN_W'(1);
    end

    vld_sr_d     = '0;
    last_sr_d    = '0;
    vld_sr_d[0]  = issue;
    last_sr_d[0] = issue && (rem_q == LEN_W'(1));
    for (int i = 1; i < READ_LAT; i++) begin
      vld_sr_d[i]  = vld_sr_q[i-1];
      last_sr_d[i] = last_sr_q[i-1];
    end

    // A zero-length command completes at once without touching the RAM.
    done_d = start_zero || drain_exit;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q    <= '0;
      rem_q     <= '0;
      vld_sr_q  <= '0;
      last_sr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      vld_sr_q  <= vld_sr_d;
      last_sr_q <= last_sr_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_ebr_burst_reader.sv
// Bench for ebr_burst_reader: a NOREG and an OUTREG instance run the same commands side by side,
// each with its own EBR model. Expected addresses/words are queued when a burst is launched and
// popped by a negedge monitor as the DUTs issue reads and hand words over.
module tb_ebr_burst_reader;
  localparam int DW     = 9;
  localparam int AW     = 10;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 1 << AW;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] dat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_ad;
  logic [AW:0]   len_in;
  logic          dready;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  int            launch_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ebr_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  ebr_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  assign bus0.START = start;  assign bus1.START = start;
  assign bus0.BASE_AD = base_ad; assign bus1.BASE_AD = base_ad;
  assign bus0.LEN = len_in;   assign bus1.LEN = len_in;
  assign bus0.DREADY = dready; assign bus1.DREADY = dready;

  ebr_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGMODE("NOREG"), .FIFO_DEPTH(DEPTH))
    dut0 (.CLK(clk), .RST(rst), .bus(bus0));
  ebr_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGMODE("OUTREG"), .FIFO_DEPTH(DEPTH))
    dut1 (.CLK(clk), .RST(rst), .bus(bus1));

  // EBR models: array read on CE, optional output register on OCE.
  logic [DW-1:0] ram [NWORDS];
  logic [DW-1:0] ram0_q = '0;
  logic [DW-1:0] ram1_q = '0;
  logic [DW-1:0] ram1_oreg = '0;
  always @(posedge clk) begin
    if (bus0.CE) ram0_q <= ram[bus0.AD];
    if (bus1.CE) ram1_q <= ram[bus1.AD];
    if (bus1.OCE) ram1_oreg <= ram1_q;
  end
  assign bus0.DI = ram0_q;
  assign bus1.DI = ram1_oreg;

  // Per-instance views of the outputs (index 0 = NOREG, 1 = OUTREG, so READ_LAT = index+1).
  logic          m_ce[2], m_vld[2], m_last[2], m_done[2], m_busy[2], m_we[2], m_oce[2];
  logic [AW-1:0] m_ad[2];
  logic [DW-1:0] m_dout[2];
  assign m_ce[0] = bus0.CE;       assign m_ce[1] = bus1.CE;
  assign m_vld[0] = bus0.DVALID;  assign m_vld[1] = bus1.DVALID;
  assign m_last[0] = bus0.DLAST;  assign m_last[1] = bus1.DLAST;
  assign m_done[0] = bus0.DONE;   assign m_done[1] = bus1.DONE;
  assign m_busy[0] = bus0.BUSY;   assign m_busy[1] = bus1.BUSY;
  assign m_we[0] = bus0.WE;       assign m_we[1] = bus1.WE;
  assign m_oce[0] = bus0.OCE;     assign m_oce[1] = bus1.OCE;
  assign m_ad[0] = bus0.AD;       assign m_ad[1] = bus1.AD;
  assign m_dout[0] = bus0.DOUT;   assign m_dout[1] = bus1.DOUT;

  // Scoreboard state
  exp_t          exp_w [2][$];
  logic [AW-1:0] exp_a [2][$];
  int            ce_cnt[2], acc_cnt[2], done_cnt[2], first_ce[2], done_cyc[2];
  int            outst[2], max_out[2];
  logic          stall_q[2];
  logic [DW:0]   stall_w[2];

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               name, k, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (m_ce[k]) begin
          if (ce_cnt[k] == 0) first_ce[k] = cyc;
          ce_cnt[k]++;
          outst[k]++;
          chk("we_oce", k, int'({m_we[k], m_oce[k]}), 1);
          if (exp_a[k].size() == 0) chk("ce_unexpected", k, 1, 0);
          else chk("ad", k, int'(m_ad[k]), int'(exp_a[k].pop_front()));
        end
        if (stall_q[k])
          chk("stall_hold", k, int'({m_vld[k], m_last[k], m_dout[k]}), int'({1'b1, stall_w[k]}));
        if (m_vld[k] && dready) begin
          acc_cnt[k]++;
          outst[k]--;
          if (exp_w[k].size() == 0) begin
            chk("word_unexpected", k, 1, 0);
          end else begin
            e = exp_w[k].pop_front();
            chk("dout", k, int'(m_dout[k]), int'(e.dat));
            chk("dlast", k, int'(m_last[k]), int'(e.last));
          end
        end
        if (outst[k] > max_out[k]) max_out[k] = outst[k];
        stall_q[k] = m_vld[k] && !dready;
        stall_w[k] = {m_last[k], m_dout[k]};
        if (m_done[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
        end
      end
    end
  end

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      ce_cnt[k] = 0; acc_cnt[k] = 0; done_cnt[k] = 0;
      first_ce[k] = -1; done_cyc[k] = -1;
      outst[k] = 0; max_out[k] = 0; stall_q[k] = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the START edge.
  task automatic launch(input int base, input int len);
    logic [AW-1:0] a;
    exp_t          e;
    clear_stats();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < len; i++) begin
        a = AW'(base + i);
        e.last = (i == len - 1);
        e.dat  = ram[a];
        exp_a[k].push_back(a);
        exp_w[k].push_back(e);
      end
    end
    launch_cyc = cyc;
    start   = 1'b1;
    base_ad = AW'(base);
    len_in  = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: DREADY held high; mode 1: random DREADY with a 10-cycle low window.
  task automatic wait_done(input int mode, input int budget);
    int n = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < budget) begin
      if (mode == 1) dready = (n >= 4 && n < 14) ? 1'b0 : ($urandom_range(0, 1) == 1);
      else dready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", 0, int'(n < budget), 1);
    dready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic end_checks(input int len, input int mode);
    for (int k = 0; k < 2; k++) begin
      chk("ce_count", k, ce_cnt[k], len);
      chk("words", k, acc_cnt[k], len);
      chk("done_count", k, done_cnt[k], 1);
      chk("exp_left", k, exp_w[k].size() + exp_a[k].size(), 0);
      chk("credit", k, int'(max_out[k] <= DEPTH), 1);
      if (mode == 0 && len > 0) begin
        chk("first_ce", k, first_ce[k], launch_cyc + 1);
        // DONE sits N+READ_LAT+1 cycles after the first CE cycle, i.e. the 7th (NOREG)
        // or 8th (OUTREG) cycle of a 4-word burst when the first CE cycle is cycle 1.
        chk("done_lat", k, done_cyc[k] - first_ce[k], len + (k + 1) + 1);
      end
    end
  endtask

  task automatic reset_checks();
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, int'(m_busy[k]), 0);
      chk("rst_done", k, int'(m_done[k]), 0);
      chk("rst_ce", k, int'(m_ce[k]), 0);
      chk("rst_ad", k, int'(m_ad[k]), 0);
      chk("rst_we", k, int'(m_we[k]), 0);
      chk("rst_oce", k, int'(m_oce[k]), 1);
      chk("rst_dvalid", k, int'(m_vld[k]), 0);
      chk("rst_dlast", k, int'(m_last[k]), 0);
      chk("rst_dout", k, int'(m_dout[k]), 0);
    end
  endtask

  initial begin
    int n;
    int base, len, mode;
    rst = 1'b1; start = 1'b0; base_ad = '0; len_in = '0; dready = 1'b1;
    // value = address in the lower half; the upper half is scrambled so bit 9 of AD matters
    for (int a = 0; a < NWORDS; a++) ram[a] = DW'(a) ^ ((a >= 512) ? 9'h155 : 9'h000);
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); reset_checks();
    @(posedge clk); #1;

    // NOREG/OUTREG basic burst
    launch('h010, 4);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("busy_after_start", k, int'(m_busy[k]), 1);
    @(posedge clk); #1;
    wait_done(0, 100); end_checks(4, 0);

    // address wrap
    launch('h3FE, 4); wait_done(0, 100); end_checks(4, 0);

    // random back-pressure with a long stall
    launch('h155, 16); wait_done(1, 2000); end_checks(16, 1);
    for (int k = 0; k < 2; k++) chk("credit_fill", k, max_out[k], DEPTH);

    // zero-length command
    launch('h055, 0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("len0_done", k, int'(m_done[k]), 1);
      chk("len0_busy", k, int'(m_busy[k]), 0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("len0_done_drop", k, int'(m_done[k]), 0);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    end_checks(0, 0);

    // START while busy is ignored
    launch('h020, 12);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; base_ad = 'h300; len_in = 5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 200); end_checks(12, 0);

    // reset mid-burst, then a clean burst
    launch('h040, 8);
    n = 0;
    while (acc_cnt[0] < 3 && n < 50) begin @(posedge clk); #1; n++; end
    chk("rst_wait", 0, int'(n < 50), 1);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin exp_w[k].delete(); exp_a[k].delete(); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stats();
    @(negedge clk); reset_checks();
    @(posedge clk); #1;
    launch('h100, 2); wait_done(0, 100); end_checks(2, 0);

    // full address sweep
    launch(0, NWORDS); wait_done(0, NWORDS + 200); end_checks(NWORDS, 0);

    // random bursts
    for (int t = 0; t < 6; t++) begin
      base = $urandom_range(0, NWORDS - 1);
      len  = $urandom_range(1, 40);
      mode = $urandom_range(0, 1);
      launch(base, len); wait_done(mode, 1000); end_checks(len, mode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
